// File: rtl/sram_delta_arb.sv
// sram_delta_arb: round-robin arbiter that lets two requesters share one
// single-port 64x32 delta-cache SRAM (one access per cycle), plus a zero-fill
// sweep of the whole array because the macro's own reset is tied off.
// Define SRAM_DELTA_ARB_CLEAR_EN to build the clear sweep (CLEAR state,
// counter, clr_start handling); without it reset enters arbitration directly.
module sram_delta_arb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  rvalid_a,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  sram_cs_n,
  output logic                  sram_wr_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  logic                  in_clear;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ptr_q;      // 0: port A wins a tie, 1: port B wins
  logic                  ptr_d;
  logic                  gnt_a_c;
  logic                  gnt_b_c;
  logic                  rvalid_a_q;
  logic                  rvalid_b_q;

`ifdef SRAM_DELTA_ARB_CLEAR_EN
  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_d;

  // State and sweep counter; any reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Walk every address once, then arbitrate until another clear is requested.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          state_d   = ARB;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ARB: begin
        if (clr_start) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign in_clear = (state_q == CLEAR);
  assign clr_addr = clr_cnt_q;
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign in_clear         = 1'b0;
  assign clr_addr         = '0;
`endif

  // Round-robin grant: a lone requester wins, a tie goes to the pointer's port,
  // and the pointer then favours the port that was not served.
  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    ptr_d   = ptr_q;
    if (!rst && !in_clear) begin
      if (req_a && (!req_b || !ptr_q)) begin
        gnt_a_c = 1'b1;
        ptr_d   = 1'b1;
      end else if (req_b) begin
        gnt_b_c = 1'b1;
        ptr_d   = 1'b0;
      end
    end
  end

  // Priority pointer and one-cycle read-valid pipeline; reset drops pending reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rvalid_a_q <= gnt_a_c & ~we_a;
      rvalid_b_q <= gnt_b_c & ~we_b;
    end
  end

  assign gnt_a    = gnt_a_c;
  assign gnt_b    = gnt_b_c;
  assign rvalid_a = rvalid_a_q & ~rst;
  assign rvalid_b = rvalid_b_q & ~rst;
  assign rdata_a  = rvalid_a ? sram_dout : '0;
  assign rdata_b  = rvalid_b ? sram_dout : '0;

  // SRAM port mux: sweep writes zeros, otherwise the granted port drives the macro.
  always_comb begin
    sram_cs_n = 1'b1;
    sram_wr_n = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    clr_busy  = 1'b0;
    if (!rst) begin
      if (in_clear) begin
        sram_cs_n = 1'b0;
        sram_wr_n = 1'b0;
        sram_addr = clr_addr;
        clr_busy  = 1'b1;
      end else if (gnt_a_c) begin
        sram_cs_n = 1'b0;
        sram_wr_n = ~we_a;
        sram_addr = addr_a;
        sram_din  = wdata_a;
      end else if (gnt_b_c) begin
        sram_cs_n = 1'b0;
        sram_wr_n = ~we_b;
        sram_addr = addr_b;
        sram_din  = wdata_b;
      end
    end
  end

endmodule

// File: doc/sram_delta_arb.md
# sram_delta_arb

Two-port round-robin arbiter and clear sequencer for the single-port delta-cache SRAM (64 x 32, synchronous write, registered-address read). It sits between two requester blocks (port A, port B) and the SRAM macro, which allows one access per cycle. It also runs a zero-fill sweep of the whole array after reset or on command, because the macro's own array reset is not used (its `rst_n` is tied high).

## Interface
- `ADDR_WIDTH`, 6: SRAM address width.
- `DATA_WIDTH`, 32: SRAM word width.
- `MEM_DEPTH`, 64: number of words; the clear sweep covers addresses 0..MEM_DEPTH-1.
- `clk` input 1: single clock; every register updates on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `req_a` / `req_b` input 1: access request; held until granted.
- `we_a` / `we_b` input 1: 1 = write, 0 = read; held with req.
- `addr_a` / `addr_b` input ADDR_WIDTH: access address; held with req.
- `wdata_a` / `wdata_b` input DATA_WIDTH: write data; held with req.
- `gnt_a` / `gnt_b` output 1: combinational grant; the access transfers in a cycle with req && gnt.
- `rvalid_a` / `rvalid_b` output 1: read data valid; registered.
- `rdata_a` / `rdata_b` output DATA_WIDTH: read data; valid only while the matching rvalid is high.
- `clr_start` input 1: one-cycle pulse that requests a full zero-fill.
- `clr_busy` output 1: high while the clear sweep runs.
- `sram_cs_n` output 1: SRAM chip select, active-low.
- `sram_wr_n` output 1: SRAM write enable, active-low.
- `sram_addr` output ADDR_WIDTH: SRAM address.
- `sram_din` output DATA_WIDTH: SRAM write data.
- `sram_dout` input DATA_WIDTH: SRAM read data. It reflects the address the SRAM sampled on the previous edge.

## Operation
- FSM states:
  - CLEAR: zero-fill sweep in progress.
  - ARB: normal arbitration.
- Reset: the state resets to CLEAR, the clear counter to 0 and the priority pointer to A.
- While `rst` = 1, all outputs are forced to their inactive values:
  - `gnt_*` = 0, `rvalid_*` = 0, `rdata_*` = 0;
  - `sram_cs_n` = 1, `sram_wr_n` = 1;
  - `sram_addr` = 0, `sram_din` = 0;
  - `clr_busy` = 0.
- CLEAR state:
  - Each cycle: `sram_cs_n` = 0, `sram_wr_n` = 0, `sram_addr` = counter, `sram_din` = 0, `clr_busy` = 1.
  - The counter increments each cycle. After the write at MEM_DEPTH-1, the counter returns to 0 and the state moves to ARB.
  - `gnt_*` = 0 throughout, and requesters stall.
  - `clr_start` is ignored; the sweep does not restart.
- ARB state, single request:
  - The requesting port is granted and the pointer moves to the other port.
- ARB state, both ports requesting:
  - The port named by the pointer is granted and the pointer moves to the other port.
- ARB state, no request:
  - `sram_cs_n` = 1 and the pointer is unchanged.
- Granted access:
  - `sram_cs_n` = 0, `sram_wr_n` = !we of the granted port.
  - `sram_addr` and `sram_din` are muxed from the granted port.
- Read completion: a read granted in cycle N gives `rvalid_x` = 1 in cycle N+1.
  - `rdata_x` = `sram_dout`, passed through combinationally and gated by rvalid_x; otherwise 0.
  - rvalid is a single-cycle pulse per read; back-to-back reads give consecutive pulses.
- `clr_start` in ARB:
  - Any grant in that same cycle still completes, including its rvalid in the next cycle.
  - The state enters CLEAR on the next cycle.
- No hazards arise: exactly one SRAM access occurs per cycle, and a write in cycle N+1 does not disturb the data read out in cycle N+1.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req, the state and the pointer.
- Write latency: the SRAM is updated at the end of the grant cycle.
- Read latency: data is available one cycle after the grant, with no stall.
- Clear duration: exactly MEM_DEPTH cycles in CLEAR. The first ARB grant is possible in cycle MEM_DEPTH after reset release, counting the first post-reset cycle as 0.
- Throughput: 1 access per cycle. Under continuous dual requests, each port gets 1 access every 2 cycles.
- Reset during CLEAR or ARB:
  - Pending rvalid is dropped and the pointer returns to A.
  - The sweep restarts from 0 after release.

## Configuration
- `SRAM_DELTA_ARB_CLEAR_EN` defined:
  - The CLEAR state, counter and `clr_start` handling are built as described.
- `SRAM_DELTA_ARB_CLEAR_EN` not defined:
  - There is no CLEAR state; reset enters ARB directly.
  - `clr_start` is ignored and `clr_busy` is tied 0.
  - Array contents after reset are undefined unless the SRAM reset is used.

## Test plan
- Reset, then release: `clr_busy` = 1 for 64 cycles while `sram_addr` steps 0..63 with cs_n = 0, wr_n = 0 and din = 0. A port A read of addr 63 afterwards gives `rdata_a` = 0x00000000.
- Port A writes 0xDEADBEEF to addr 5 in cycle N; port B reads addr 5 in cycle N+1. Required: `gnt_b` = 1 in N+1, and `rvalid_b` = 1 with `rdata_b` = 0xDEADBEEF in N+2.
- Both ports hold req continuously after clear. Required: grants alternate A, B, A, B, starting with A; `sram_addr` alternates between addr_a and addr_b.
- Port A writes 0x12345678 to addr 10, then `clr_start` is pulsed. Required: gnt_* = 0 for 64 cycles, then a read of addr 10 gives 0x00000000.
- `rst` is asserted for one cycle when the clear counter is at 20. Required: outputs go inactive, and after release the sweep restarts at addr 0 and lasts the full 64 cycles.
- Port A issues back-to-back reads of addr 63 then addr 0 (written earlier with 0xA5A5A5A5 and 0x5A5A5A5A). Required: rvalid_a is high in two consecutive cycles with rdata_a = 0xA5A5A5A5, then 0x5A5A5A5A.
